// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results (A) and long-latency results (B, FIFO-buffered) into the RF write port.
// Latency: 1 cycle from selection to rf_write_*; B entries wait in a DEPTH-entry FIFO until A leaves a slot.
// Backpressure: b_ready_o low while the FIFO is full; a_ready_o low for one cycle once the FIFO head has lost STARVE_LIMIT times.
// Optional feature macro: WB_FORWARD_EN adds qN_fwd_valid_o/qN_fwd_data_o forwarding from the output stage.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [4:0]  b_addr_i,
    input  logic [31:0] b_data_i,
    input  logic [4:0]  q1_addr_i,
    output logic        q1_hit_o,
    input  logic [4:0]  q2_addr_i,
    output logic        q2_hit_o,
`ifdef WB_FORWARD_EN
    output logic        q1_fwd_valid_o,
    output logic [31:0] q1_fwd_data_o,
    output logic        q2_fwd_valid_o,
    output logic [31:0] q2_fwd_data_o,
`endif
    output logic        rf_write_enable_o,
    output logic [4:0]  rf_write_addr_o,
    output logic [31:0] rf_write_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;

    logic            fifo_empty;
    logic            a_fire;
    logic            b_fire;
    logic            pop;
    logic            sel_vld;
    wb_ent_t         sel;
    logic            q1_fifo;
    logic            q2_fifo;
    logic            q1_out;
    logic            q2_out;

    // Handshakes depend only on registered count/starvation state, never on a same-cycle pop.
    always_comb begin
        fifo_empty = (count == '0);
        b_ready_o  = (count != CW'(DEPTH));
        a_ready_o  = !((starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty);
        a_fire     = a_valid_i && a_ready_o;
        b_fire     = b_valid_i && b_ready_o;
        pop        = !a_fire && !fifo_empty;
    end

    // Port A always wins when it transfers; otherwise the FIFO head drains.
    always_comb begin
        sel_vld = a_fire || pop;
        sel     = mem[rd_ptr];
        if (a_fire) begin
            sel = '{addr: a_addr_i, data: a_data_i};
        end
    end

    // Starvation counter: counts A wins over a non-empty FIFO, clears on any pop or when empty.
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || fifo_empty) begin
            starve_nxt = '0;
        end else if (a_fire && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // FIFO storage; contents need no reset because count gates validity.
    always_ff @(posedge clk_i) begin
        if (b_fire) begin
            mem[wr_ptr] <= '{addr: b_addr_i, data: b_data_i};
        end
    end

    // FIFO pointers, occupancy and starvation state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (b_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({b_fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
        end
    end

    // Registered write port; x0 writes complete the handshake but never enable the RF write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_write_enable_o <= 1'b0;
            rf_write_addr_o   <= '0;
            rf_write_data_o   <= '0;
        end else begin
            rf_write_enable_o <= sel_vld && (sel.addr != 5'd0);
            if (sel_vld) begin
                rf_write_addr_o <= sel.addr;
                rf_write_data_o <= sel.data;
            end
        end
    end

    // Hazard lookup across valid FIFO entries (oldest at rd_ptr) and the output stage.
    always_comb begin
        q1_fifo = 1'b0;
        q2_fifo = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (mem[rd_ptr + PW'(i)].addr == q1_addr_i) q1_fifo = 1'b1;
                if (mem[rd_ptr + PW'(i)].addr == q2_addr_i) q2_fifo = 1'b1;
            end
        end
        q1_out = rf_write_enable_o && (rf_write_addr_o == q1_addr_i);
        q2_out = rf_write_enable_o && (rf_write_addr_o == q2_addr_i);
    end

`ifdef WB_FORWARD_EN
    // Output-stage matches are forwarded instead of stalling; only FIFO matches still report a hit.
    always_comb begin
        q1_hit_o       = (q1_addr_i != 5'd0) && q1_fifo;
        q2_hit_o       = (q2_addr_i != 5'd0) && q2_fifo;
        q1_fwd_valid_o = (q1_addr_i != 5'd0) && q1_out;
        q2_fwd_valid_o = (q2_addr_i != 5'd0) && q2_out;
        q1_fwd_data_o  = rf_write_data_o;
        q2_fwd_data_o  = rf_write_data_o;
    end
`else
    // Any in-flight write to the queried register is a hit.
    always_comb begin
        q1_hit_o = (q1_addr_i != 5'd0) && (q1_fifo || q1_out);
        q2_hit_o = (q2_addr_i != 5'd0) && (q2_fifo || q2_out);
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: queue-based reference model plus write scoreboard.
// Stimulus is issued once per cycle; expected RF writes are queued with the cycle they must appear in.
// A negedge monitor pops the scoreboard whenever a write is due and compares it with the DUT.
module tb_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, q1_addr, q2_addr;
    logic [31:0] a_data, b_data;
    logic        q1_hit, q2_hit;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
`ifdef WB_FORWARD_EN
    logic        q1_fv, q2_fv;
    logic [31:0] q1_fd, q2_fd;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
        .q1_addr_i(q1_addr), .q1_hit_o(q1_hit), .q2_addr_i(q2_addr), .q2_hit_o(q2_hit),
`ifdef WB_FORWARD_EN
        .q1_fwd_valid_o(q1_fv), .q1_fwd_data_o(q1_fd),
        .q2_fwd_valid_o(q2_fv), .q2_fwd_data_o(q2_fd),
`endif
        .rf_write_enable_o(rf_we), .rf_write_addr_o(rf_addr), .rf_write_data_o(rf_data)
    );

    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } exp_t;

    // Reference model state: pending B results in arrival order, head loss count, last write port contents.
    ent_t        fifo_m[$];
    exp_t        exp_q[$];
    int          starve_m;
    bit          out_we_m;
    logic [4:0]  out_addr_m;
    logic [31:0] out_data_m;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit fifo_has(input logic [4:0] q);
        foreach (fifo_m[i]) if (fifo_m[i].addr == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_hit(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
`ifdef WB_FORWARD_EN
        return fifo_has(q);
`else
        return fifo_has(q) || (out_we_m && out_addr_m == q);
`endif
    endfunction

    // Monitor: every cycle the write port must show exactly the write due this cycle, if any.
    always @(negedge clk) begin
        bit want;
        if (mon_en) begin
            want = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
            chk("mon_we", rf_we, want);
            if (want) begin
                chk("mon_addr", rf_addr, exp_q[0].addr);
                chk("mon_data", rf_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus: drive, check registered-state outputs, then advance the model.
    task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic [4:0] q1, input logic [4:0] q2);
        bit   ar_e, br_e, afire, bfire, pop, was_empty, sv;
        ent_t sel;
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; q1_addr = q1; q2_addr = q2;
        #1;
        was_empty = (fifo_m.size() == 0);
        ar_e = !(starve_m == STARVE_LIMIT && !was_empty);
        br_e = (fifo_m.size() != DEPTH);
        chk("a_ready", a_ready, ar_e);
        chk("b_ready", b_ready, br_e);
        chk("q1_hit", q1_hit, exp_hit(q1));
        chk("q2_hit", q2_hit, exp_hit(q2));
        chk("rf_addr_hold", rf_addr, out_addr_m);
        chk("rf_data_hold", rf_data, out_data_m);
`ifdef WB_FORWARD_EN
        chk("q1_fwd_valid", q1_fv, (q1 != 0) && out_we_m && out_addr_m == q1);
        chk("q2_fwd_valid", q2_fv, (q2 != 0) && out_we_m && out_addr_m == q2);
        if (q1 != 0 && out_we_m && out_addr_m == q1) chk("q1_fwd_data", q1_fd, out_data_m);
        if (q2 != 0 && out_we_m && out_addr_m == q2) chk("q2_fwd_data", q2_fd, out_data_m);
`endif
        afire = av && ar_e;
        bfire = bv && br_e;
        pop   = !afire && !was_empty;
        if (r) begin
            fifo_m.delete();
            starve_m   = 0;
            out_we_m   = 1'b0;
            out_addr_m = '0;
            out_data_m = '0;
        end else begin
            sv  = afire || pop;
            sel = '{aa, ad};
            if (!afire && pop) sel = fifo_m.pop_front();
            if (pop || was_empty) starve_m = 0;
            else if (afire && starve_m < STARVE_LIMIT) starve_m++;
            if (bfire) fifo_m.push_back('{ba, bd});
            out_we_m = sv && (sel.addr != 5'd0);
            if (sv) begin
                out_addr_m = sel.addr;
                out_data_m = sel.data;
            end
            if (out_we_m) exp_q.push_back('{sel.addr, sel.data, cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0; q1_addr = '0; q2_addr = '0;
        starve_m = 0; out_we_m = 1'b0; out_addr_m = '0; out_data_m = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state.
        chk("rst_we", rf_we, 1'b0);
        chk("rst_addr", rf_addr, 5'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_b_ready", b_ready, 1'b1);
        chk("rst_a_ready", a_ready, 1'b1);

        // A writes x5, then a write to x0 that must not enable the RF.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(5'd0, 5'd5);

        // B-only traffic retires in arrival order.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 5'd3, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h33, 5'd6, 5'd4);
        repeat (3) idle(5'd6, 5'd3);

        // A busy every cycle while B fills the FIFO: exercises full and starvation release.
        for (int i = 0; i < 24; i++)
            step(1'b0, 1'b1, 5'(8 + i % 8), 32'hA000 + i, i < 6, 5'(16 + i), 32'hB000 + i,
                 5'(16 + i % 6), 5'(8 + i % 8));
        repeat (6) idle(5'd16, 5'd17);

        // Pending x7 visible to the hazard query until it leaves the output stage.
        step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        repeat (4) idle(5'd7, 5'd0);

        // Reset with three buffered entries and a write in flight: nothing buffered may appear.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'(20 + i), 32'hC0 + i, 1'b1, 5'(24 + i), 32'hD0 + i, 5'd24, 5'd20);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd24, 5'd25);
        repeat (6) idle(5'd24, 5'd26);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        repeat (12) idle(5'd0, 5'd0);
        chk("drain_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
